sprite_line_scheduler: RTL and testbench

//  Multi-sprite scanline scheduler for the hvsync_generator/sprite path. It holds a table of NUM_SPRITES sprite positions.

---
 rtl/sprite_line_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_sprite_line_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_scheduler.sv
// Scanline sprite scheduler: scans the sprite table during hblank, fetches one ROM row per visible sprite,
// and serializes display slots MSB-first. Optional macro SPRITE_COLLISION_EN enables sticky overlap detection.
module sprite_line_scheduler #(
  parameter int NUM_SPRITES = 8,
  parameter int SLOTS       = 4,
  parameter int SPRITE_H    = 16,
  parameter int SCAN_START  = 256,
  parameter int V_TOTAL     = 262,
  localparam int IW = $clog2(NUM_SPRITES),
  localparam int SW = $clog2(SLOTS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [8:0]    hpos,
  input  logic [8:0]    vpos,
  input  logic          tbl_we,
  input  logic [IW-1:0] tbl_addr,
  input  logic [8:0]    tbl_x,
  input  logic [8:0]    tbl_y,
  input  logic          tbl_en,
  output logic          rom_req,
  output logic [3:0]    rom_yofs,
  input  logic [7:0]    rom_bits,
  input  logic          rom_ack,
  output logic          gfx,
  output logic [SW-1:0] gfx_slot,
  output logic          overflow,
  output logic          busy,
  output logic          collision
);
  localparam int KW = $clog2(SLOTS + 1);

  // state | meaning
  // IDLE  | waiting for SCAN_START
  // SCAN  | testing table entry idx against the next line
  // FETCH | ROM request outstanding for entry idx
  typedef enum logic [1:0] {IDLE, SCAN, FETCH} state_t;

  state_t                 state, state_nx;
  logic [8:0]             ent_x [NUM_SPRITES];
  logic [8:0]             ent_y [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] ent_en;
  logic [IW-1:0]          idx, idx_nx;
  logic [KW-1:0]          cnt, cnt_nx;
  logic                   overflow_nx;
  logic [3:0]             yofs_nx;
  logic [8:0]             fetch_x, fetch_x_nx;
  logic                   pend_clr, pend_load;
  logic [SLOTS-1:0]       pend_v, disp_v;
  logic [SLOTS-1:0][8:0]  pend_x, disp_x;
  logic [SLOTS-1:0][7:0]  pend_bits, disp_bits;
  logic [SLOTS-1:0][8:0]  off;
  logic [SLOTS-1:0]       pix;
  logic                   line_start, last_ent, hit;
  logic [8:0]             next_y, dy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_en <= '0;
      for (int e = 0; e < NUM_SPRITES; e++) begin
        ent_x[e] <= '0;
        ent_y[e] <= '0;
      end
    end else if (tbl_we) begin
      ent_x[tbl_addr]  <= tbl_x;
      ent_y[tbl_addr]  <= tbl_y;
      ent_en[tbl_addr] <= tbl_en;
    end
  end

  // Modulo-512 difference makes sprites near the bottom wrap onto the top lines.
  assign line_start = (hpos == 9'd0);
  assign last_ent   = (idx == IW'(NUM_SPRITES - 1));
  assign next_y     = (vpos == 9'(V_TOTAL - 1)) ? 9'd0 : vpos + 9'd1;
  assign dy         = next_y - ent_y[idx];
  assign hit        = ent_en[idx] && (dy < 9'(SPRITE_H));

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    cnt_nx      = cnt;
    overflow_nx = overflow;
    yofs_nx     = rom_yofs;
    fetch_x_nx  = fetch_x;
    pend_clr    = 1'b0;
    pend_load   = 1'b0;
    case (state)
      IDLE: begin
        if (hpos == 9'(SCAN_START)) begin
          state_nx    = SCAN;
          idx_nx      = '0;
          cnt_nx      = '0;
          overflow_nx = 1'b0;
          pend_clr    = 1'b1;
        end
      end
      SCAN: begin
        if (hit) begin
          if (cnt == KW'(SLOTS)) begin
            overflow_nx = 1'b1;
            state_nx    = IDLE;
          end else begin
            state_nx   = FETCH;
            yofs_nx    = dy[3:0];
            fetch_x_nx = ent_x[idx];
          end
        end else if (last_ent) begin
          state_nx = IDLE;
        end else begin
          idx_nx = idx + IW'(1);
        end
      end
      FETCH: begin
        if (rom_ack) begin
          pend_load = 1'b1;
          cnt_nx    = cnt + KW'(1);
          if (last_ent) begin
            state_nx = IDLE;
          end else begin
            state_nx = SCAN;
            idx_nx   = idx + IW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // Line start aborts a late scan; slots already fetched stay in the pending set.
    if (line_start) begin
      state_nx  = IDLE;
      pend_load = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
      rom_yofs <= '0;
      fetch_x  <= '0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      cnt      <= cnt_nx;
      overflow <= overflow_nx;
      rom_yofs <= yofs_nx;
      fetch_x  <= fetch_x_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_v    <= '0;
      pend_x    <= '0;
      pend_bits <= '0;
      disp_v    <= '0;
      disp_x    <= '0;
      disp_bits <= '0;
    end else begin
      for (int s = 0; s < SLOTS; s++) begin
        if (pend_clr) begin
          pend_v[s] <= 1'b0;
        end else if (pend_load && cnt == KW'(s)) begin
          pend_v[s]    <= 1'b1;
          pend_x[s]    <= fetch_x;
          pend_bits[s] <= rom_bits;
        end
      end
      if (line_start) begin
        disp_v    <= pend_v;
        disp_x    <= pend_x;
        disp_bits <= pend_bits;
      end
    end
  end

  assign rom_req = (state == FETCH) && !line_start;
  assign busy    = (state != IDLE);

  // Right edge is compared 10 bits wide so sprites near column 511 clip instead of wrapping.
  always_comb begin
    off = '0;
    pix = '0;
    for (int s = 0; s < SLOTS; s++) begin
      off[s] = hpos - disp_x[s];
      pix[s] = disp_v[s] && (hpos >= disp_x[s]) &&
               ({1'b0, hpos} < ({1'b0, disp_x[s]} + 10'd8)) &&
               disp_bits[s][~off[s][2:0]];
    end
  end

  assign gfx = |pix;

  always_comb begin
    gfx_slot = '0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (pix[s]) gfx_slot = SW'(s);
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic coll_r;
  logic multi;
  logic seen;

  always_comb begin
    multi = 1'b0;
    seen  = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      if (pix[s] && seen) multi = 1'b1;
      if (pix[s]) seen = 1'b1;
    end
  end

  // Frame start clears the sticky flag, but an overlap on that same pixel still reports.
  assign collision = (coll_r && !(line_start && vpos == 9'd0)) || multi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) coll_r <= 1'b0;
    else       coll_r <= collision;
  end
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler: pixel vector table plus hand sequences for scan,
// overflow, ROM handshake, wrap, abort, collision and reset corner cases.
module tb_sprite_line_scheduler;
  localparam int SCAN_START = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] hpos, vpos;
  logic       tbl_we;
  logic [2:0] tbl_addr;
  logic [8:0] tbl_x, tbl_y;
  logic       tbl_en;
  logic       rom_req;
  logic [3:0] rom_yofs;
  logic [7:0] rom_bits;
  logic       rom_ack;
  logic       gfx;
  logic [1:0] gfx_slot;
  logic       overflow, busy, collision;

  sprite_line_scheduler dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_x(tbl_x), .tbl_y(tbl_y), .tbl_en(tbl_en),
    .rom_req(rom_req), .rom_yofs(rom_yofs), .rom_bits(rom_bits), .rom_ack(rom_ack),
    .gfx(gfx), .gfx_slot(gfx_slot), .overflow(overflow), .busy(busy), .collision(collision)
  );

  always #5 clk = ~clk;

  // ROM model: ack after lat cycles of request; bits are garbage except on the ack cycle.
  logic [7:0] rom_mem [16];
  int         lat = 0;
  int         wait_cnt = 0;
  int         run = 0;
  int         last_run = 0;
  int         yofs_moves = 0;
  logic       prev_req = 1'b0;
  logic [3:0] prev_yofs = 4'd0;
  logic [3:0] ack_q [$];

  assign rom_ack  = rom_req && (wait_cnt == lat);
  assign rom_bits = rom_ack ? rom_mem[rom_yofs] : ~rom_mem[rom_yofs];

  always @(posedge clk) begin
    if (rom_req && !rom_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
    if (rom_req) begin
      run <= run + 1;
      if (prev_req && rom_yofs != prev_yofs) yofs_moves <= yofs_moves + 1;
    end else begin
      run <= 0;
    end
    if (rom_ack) begin
      ack_q.push_back(rom_yofs);
      last_run <= run + 1;
      run      <= 0;
    end
    prev_req  <= rom_req;
    prev_yofs <= rom_yofs;
  end

  int total = 0;
  int bad = 0;

  typedef struct {
    int         grp;
    logic [8:0] h;
    logic       g;
    logic [1:0] s;
  } vec_t;
  vec_t vt [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic addv(input int grp, input int h, input logic g, input int s);
    vt.push_back('{grp, 9'(h), g, 2'(s)});
  endtask

  task automatic run_group(input int grp);
    foreach (vt[j]) begin
      if (vt[j].grp == grp) begin
        hpos = vt[j].h;
        #1;
        chk($sformatf("g%0d_gfx_h%0d", grp, vt[j].h), 32'(gfx), 32'(vt[j].g));
        chk($sformatf("g%0d_slot_h%0d", grp, vt[j].h), 32'(gfx_slot), 32'(vt[j].s));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int x, input int y, input logic en);
    tbl_we = 1'b1; tbl_addr = 3'(a); tbl_x = 9'(x); tbl_y = 9'(y); tbl_en = en;
    step();
    tbl_we = 1'b0;
  endtask

  task automatic start_scan(input int v);
    vpos = 9'(v);
    hpos = 9'(SCAN_START);
    step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      hpos = hpos + 9'd1;
      step();
      n++;
    end
    chk("scan_done", 32'(busy), 32'd0);
  endtask

  task automatic prep_line(input int v);
    ack_q.delete();
    start_scan(v);
    drain();
  endtask

  task automatic swap(input int v);
    hpos = 9'd0;
    vpos = 9'(v);
    step();
    hpos = 9'd1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    logic       exp_c;
    int         n;
`ifdef SPRITE_COLLISION_EN
    exp_c = 1'b1;
`else
    exp_c = 1'b0;
`endif
    // Pixel vector table: {group, hpos, gfx, gfx_slot}
    for (int j = 100; j <= 107; j++) addv(1, j, 1'b0, 0);
    pat = 8'hA5;
    addv(2, 99, 1'b0, 0);
    for (int j = 0; j < 8; j++) addv(2, 100 + j, pat[7-j], 0);
    addv(2, 108, 1'b0, 0);
    addv(3, 30, 1'b1, 0);  addv(3, 50, 1'b1, 1);  addv(3, 70, 1'b1, 2);
    addv(3, 90, 1'b1, 3);  addv(3, 91, 1'b0, 0);  addv(3, 112, 1'b0, 0);
    for (int j = 0; j < 8; j++) addv(4, 200 + j, pat[7-j], 0);
    addv(5, 100, 1'b1, 0); addv(5, 101, 1'b0, 0); addv(5, 120, 1'b0, 0);
    addv(5, 140, 1'b1, 1); addv(5, 141, 1'b0, 0); addv(5, 147, 1'b1, 1);
    addv(5, 508, 1'b1, 2); addv(5, 509, 1'b0, 0); addv(5, 510, 1'b1, 2);
    addv(5, 511, 1'b0, 0); addv(5, 3, 1'b0, 0);
    addv(6, 10, 1'b1, 0);  addv(6, 14, 1'b1, 0);  addv(6, 17, 1'b1, 0);
    addv(6, 18, 1'b1, 1);  addv(6, 21, 1'b1, 1);  addv(6, 22, 1'b0, 0);

    for (int r = 0; r < 16; r++) rom_mem[r] = 8'(r * 17);
    rom_mem[0] = 8'hA5;
    rom_mem[2] = 8'h81;

    reset = 1'b1; hpos = 9'd300; vpos = 9'd0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_x = '0; tbl_y = '0; tbl_en = 1'b0;
    #12;
    chk("rst_rom_req", 32'(rom_req), 32'd0);
    chk("rst_rom_yofs", 32'(rom_yofs), 32'd0);
    chk("rst_gfx", 32'(gfx), 32'd0);
    chk("rst_gfx_slot", 32'(gfx_slot), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_collision", 32'(collision), 32'd0);
    reset = 1'b0;
    step();

    // Single sprite, one line above its top misses, then row 0 shows A5
    wr(0, 100, 50, 1'b1);
    prep_line(48);
    chk("above_top_fetches", 32'(ack_q.size()), 32'd0);
    swap(49);
    run_group(1);
    prep_line(49);
    chk("row0_fetches", 32'(ack_q.size()), 32'd1);
    if (ack_q.size() == 1) chk("row0_yofs", 32'(ack_q[0]), 32'd0);
    chk("row0_req_len", 32'(last_run), 32'd1);
    swap(50);
    run_group(2);
    prep_line(64);
    chk("row15_fetches", 32'(ack_q.size()), 32'd1);
    if (ack_q.size() == 1) chk("row15_yofs", 32'(ack_q[0]), 32'd15);
    prep_line(65);
    chk("below_bottom_fetches", 32'(ack_q.size()), 32'd0);

    // Five sprites on one line with four slots
    for (int e = 0; e < 5; e++) wr(e, 30 + 20 * e, 20, 1'b1);
    prep_line(19);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_fetches", 32'(ack_q.size()), 32'd4);
    swap(20);
    run_group(3);
    chk("ovf_held_in_line", 32'(overflow), 32'd1);
    start_scan(20);
    chk("ovf_cleared_at_scan", 32'(overflow), 32'd0);
    drain();

    // Delayed ack: request and row held, bits taken on the ack cycle only
    lat = 3;
    wr(0, 200, 100, 1'b1);
    for (int e = 1; e < 5; e++) wr(e, 0, 0, 1'b0);
    yofs_moves = 0;
    prep_line(99);
    chk("slow_req_len", 32'(last_run), 32'd4);
    chk("slow_yofs_moves", 32'(yofs_moves), 32'd0);
    chk("slow_fetches", 32'(ack_q.size()), 32'd1);
    swap(100);
    run_group(4);

    // Late fetch aborted by line start
    lat = 50;
    start_scan(99);
    n = 0;
    while (rom_req !== 1'b1 && n < 20) begin step(); n++; end
    chk("abort_req_seen", 32'(rom_req), 32'd1);
    hpos = 9'd0; vpos = 9'd100;
    #1;
    chk("abort_req_drop", 32'(rom_req), 32'd0);
    step();
    chk("abort_busy", 32'(busy), 32'd0);
    lat = 0;

    // Vertical wrap and right-edge clipping
    wr(0, 100, 0, 1'b1);
    wr(1, 120, 255, 1'b1);
    wr(2, 140, 510, 1'b1);
    wr(3, 508, 0, 1'b1);
    prep_line(261);
    chk("wrap_fetches", 32'(ack_q.size()), 32'd3);
    if (ack_q.size() == 3) begin
      chk("wrap_yofs_a", 32'(ack_q[0]), 32'd0);
      chk("wrap_yofs_b", 32'(ack_q[1]), 32'd2);
      chk("wrap_yofs_c", 32'(ack_q[2]), 32'd0);
    end
    swap(0);
    run_group(5);

    // Overlapping sprites
    rom_mem[0] = 8'hFF;
    wr(0, 10, 100, 1'b1);
    wr(1, 14, 100, 1'b1);
    wr(2, 0, 0, 1'b0);
    wr(3, 0, 0, 1'b0);
    prep_line(99);
    swap(100);
    hpos = 9'd13;
    #1;
    chk("coll_before", 32'(collision), 32'd0);
    hpos = 9'd14;
    #1;
    chk("coll_at_14", 32'(collision), 32'(exp_c));
    step();
    hpos = 9'd30;
    step();
    step();
    chk("coll_sticky", 32'(collision), 32'(exp_c));
    run_group(6);
    hpos = 9'd0; vpos = 9'd0;
    #1;
    chk("coll_frame_clear", 32'(collision), 32'd0);
    step();
    hpos = 9'd5;
    step();
    chk("coll_after_clear", 32'(collision), 32'd0);

    // Asynchronous reset in the middle of a fetch
    lat = 50;
    start_scan(99);
    n = 0;
    while (rom_req !== 1'b1 && n < 20) begin step(); n++; end
    chk("midfetch_req_seen", 32'(rom_req), 32'd1);
    hpos = 9'd12;
    #1;
    chk("midfetch_gfx_before", 32'(gfx), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("midfetch_rst_req", 32'(rom_req), 32'd0);
    chk("midfetch_rst_busy", 32'(busy), 32'd0);
    chk("midfetch_rst_gfx", 32'(gfx), 32'd0);
    #3;
    reset = 1'b0;
    lat = 0;
    step();
    prep_line(99);
    chk("rst_table_disabled", 32'(ack_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
